// File: rtl/alu_pkg.sv
// Shared types for the sequential stack ALU: opcode encoding, opcode width
// and the controller state encoding used by alu_seq.
package alu_pkg;

    // Opcode width is fixed by the encoding below; callers must not override it.
    localparam int OPW = 3;

    // Operation encoding as seen on the op input.
    typedef enum logic [OPW-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_t;

    // Controller states: waiting for work, multiplier iterating, result held.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH
// cycles per multiply. Operands are captured on start; the full
// 2*WIDTH-bit product is presented on prod in the same cycle that done
// pulses, so the caller registers it on that edge.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left one place per step
    logic [WIDTH-1:0]   mplier;  // multiplier, shifted right one place per step
    logic [2*WIDTH-1:0] acc;     // running sum of partial products
    logic [CW-1:0]      cnt;     // index of the partial product being added
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_sum;

    // Partial product for this step and the accumulator value after adding it.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        acc_sum = acc + addend;
    end

    // The last step is the one that adds partial product WIDTH-1.
    assign done = busy && (cnt == LAST);
    assign prod = acc_sum;

    // Operand load on start, then one shift-add step per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_sum;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU for the stack datapath, sitting between the operand latch
// (upstream) and the writeback stage (downstream).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds its payload until that edge, and the block
// never drops out_valid or changes o/cout/zero/err until out_ready is seen.
//
// Build option: define ALU_MUL_EN to include the iterative multiplier for
// op 7. Without it op 7 is a one-cycle error op (o=0, zero=1, err=1).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);

    alu_state_t         state;
    alu_state_t         state_next;
    logic               accept;
    logic               is_mul;
    logic               load_alu;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   alu_o;
    logic               alu_cout;
    logic               alu_err;
    logic [WIDTH:0]     wide;
    logic [SW-1:0]      sh;

`ifdef ALU_MUL_EN
    assign is_mul = (alu_op_t'(op) == ALU_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (i0),
        .b     (i1),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`else
    // No multiplier: op 7 takes the single-cycle path and flags err.
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // Single-cycle datapath, evaluated on the live inputs so the result can
    // be registered on the accepting edge.
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        wide     = '0;
        sh       = i1[SW-1:0];
        case (alu_op_t'(op))
            ALU_ADD: begin
                wide     = {1'b0, i0} + {1'b0, i1};
                alu_o    = wide[WIDTH-1:0];
                alu_cout = wide[WIDTH];
            end
            ALU_SUB: begin
                // Carry out of i0 + ~i1 + 1 is the no-borrow flag (i0 >= i1).
                wide     = {1'b0, i0} + {1'b0, ~i1} + (WIDTH+1)'(1);
                alu_o    = wide[WIDTH-1:0];
                alu_cout = wide[WIDTH];
            end
            ALU_AND: alu_o = i0 & i1;
            ALU_OR:  alu_o = i0 | i1;
            ALU_XOR: alu_o = i0 ^ i1;
            ALU_SHL: begin
                // Extra bit on the left catches the last bit shifted out;
                // a zero shift leaves it 0.
                wide     = {1'b0, i0} << sh;
                alu_o    = wide[WIDTH-1:0];
                alu_cout = wide[WIDTH];
            end
            ALU_SHR: begin
                // Extra bit on the right catches the last bit shifted out.
                wide     = {i0, 1'b0} >> sh;
                alu_o    = wide[WIDTH:1];
                alu_cout = wide[0];
            end
            ALU_MUL: begin
`ifdef ALU_MUL_EN
                // Result comes from the multiplier, not this path.
                alu_o   = '0;
`else
                alu_err = 1'b1;
`endif
            end
            default: alu_o = '0;
        endcase
    end

    // Ready when idle, or when the held result is being taken this cycle.
    assign in_ready  = rst_n && !mul_busy &&
                       ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign load_alu  = accept && !is_mul;
    assign out_valid = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accepted ops go to BUSY (multiply) or straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = is_mul ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result and flag registers: loaded by a single-cycle accept or by the
    // final multiplier step, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o    <= '0;
            cout <= 1'b0;
            zero <= 1'b0;
            err  <= 1'b0;
        end else if (load_alu) begin
            o    <= alu_o;
            cout <= alu_cout;
            zero <= (alu_o == '0);
            err  <= alu_err;
        end else if (mul_done) begin
            o    <= mul_prod[WIDTH-1:0];
            cout <= |mul_prod[2*WIDTH-1:WIDTH];
            zero <= (mul_prod[WIDTH-1:0] == '0);
            err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16). Builds with or without ALU_MUL_EN.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic         cout;
    logic         zero;
    logic         err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic         c;
    } vec_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .i0        (i0),
        .i1        (i1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .cout      (cout),
        .zero      (zero),
        .err       (err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: present one operation.
    task automatic drive(input logic [2:0] d_op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = d_op;
        i0       = a;
        i1       = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        i0        = '0;
        i1        = '0;
        step();
        step();
        total++;
        if ({in_ready, out_valid, o, cout, zero, err} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b o=%h c=%b z=%b e=%b, required all 0",
                     in_ready, out_valid, o, cout, zero, err);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        vec_t v[12];
        v[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};  // ADD wrap
        v[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};  // SUB borrow
        v[2]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1};  // SUB equal
        v[3]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 1'b1};  // SHL out bit 1
        v[4]  = '{3'd6, 16'h0001, 16'h0000, 16'h0001, 1'b0};  // SHR by 0
        v[5]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};  // AND
        v[6]  = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};  // OR
        v[7]  = '{3'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};  // XOR
        v[8]  = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0};  // SHR by 15
        v[9]  = '{3'd6, 16'h4003, 16'h0002, 16'h1000, 1'b1};  // SHR out bit 1
        v[10] = '{3'd5, 16'h00FF, 16'hFF08, 16'hFF00, 1'b0};  // SHL uses low 4 bits only
        v[11] = '{3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0};  // ADD no carry
        for (int k = 0; k < 12; k++) begin
            drive(v[k].op, v[k].a, v[k].b);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_pre_%0d: out_valid=%b required 0", k, out_valid);
            end
            step();
            in_valid = 1'b0;
            total++;
            if ({out_valid, o, cout, zero, err} !== {1'b1, v[k].o, v[k].c, (v[k].o == 16'h0), 1'b0}) begin
                bad++;
                $display("FAIL single_%0d: vld=%b o=%h c=%b z=%b e=%b, required vld=1 o=%h c=%b z=%b e=0",
                         k, out_valid, o, cout, zero, err, v[k].o, v[k].c, (v[k].o == 16'h0));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            total++;
            if ({out_valid, in_ready} !== 2'b01) begin
                bad++;
                $display("FAIL single_drain_%0d: vld=%b rdy=%b required vld=0 rdy=1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        v[0] = '{3'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0};
        v[1] = '{3'd4, 16'h0F0F, 16'h00FF, 16'h0FF0, 1'b0};
        v[2] = '{3'd1, 16'h0010, 16'h0001, 16'h000F, 1'b1};
        v[3] = '{3'd3, 16'h8000, 16'h0001, 16'h8001, 1'b0};
        out_ready = 1'b1;
        drive(v[0].op, v[0].a, v[0].b);
        step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_valid, in_ready, o, cout} !== {1'b1, 1'b1, v[k].o, v[k].c}) begin
                bad++;
                $display("FAIL b2b_%0d: vld=%b rdy=%b o=%h c=%b, required vld=1 rdy=1 o=%h c=%b",
                         k, out_valid, in_ready, o, cout, v[k].o, v[k].c);
            end
            if (k < 3) drive(v[k+1].op, v[k+1].a, v[k+1].b);
            else in_valid = 1'b0;
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(3'd0, 16'h0007, 16'h0008);
        step();
        for (int k = 0; k < 3; k++) begin
            // New inputs offered while stalled must not disturb the held result.
            drive(3'd2, 16'($urandom_range(0, 65535)), 16'hFFFF);
            total++;
            if ({out_valid, in_ready, o, cout, zero} !== {1'b1, 1'b0, 16'h000F, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_%0d: vld=%b rdy=%b o=%h c=%b z=%b, required vld=1 rdy=0 o=000f c=0 z=0",
                         k, out_valid, in_ready, o, cout, zero);
            end
            step();
        end
        out_ready = 1'b1;
        drive(3'd1, 16'h0009, 16'h0004);
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, o, cout} !== {1'b1, 16'h0005, 1'b1}) begin
            bad++;
            $display("FAIL hold_release: vld=%b o=%h c=%b, required vld=1 o=0005 c=1", out_valid, o, cout);
        end
        step();
        out_ready = 1'b0;
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        vec_t v[3];
        int   waited;
        v[0] = '{3'd7, 16'h0100, 16'h0101, 16'h0100, 1'b1};
        v[1] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        v[2] = '{3'd7, 16'h0003, 16'h0005, 16'h000F, 1'b0};
        drive(v[0].op, v[0].a, v[0].b);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            total++;
            if ({in_ready, out_valid} !== 2'b00) begin
                bad++;
                $display("FAIL mul_busy_cycle_%0d: rdy=%b vld=%b required rdy=0 vld=0", c, in_ready, out_valid);
            end
            step();
        end
        total++;
        if ({out_valid, o, cout, zero, err} !== {1'b1, 16'h0100, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mul_latency: vld=%b o=%h c=%b z=%b e=%b, required vld=1 o=0100 c=1 z=0 e=0",
                     out_valid, o, cout, zero, err);
        end
        step();
        out_ready = 1'b0;
        for (int k = 1; k < 3; k++) begin
            drive(v[k].op, v[k].a, v[k].b);
            step();
            in_valid = 1'b0;
            waited = 0;
            while (out_valid !== 1'b1 && waited < 40) begin
                step();
                waited++;
            end
            total++;
            if ({out_valid, o, cout, err} !== {1'b1, v[k].o, v[k].c, 1'b0}) begin
                bad++;
                $display("FAIL mul_%0d: vld=%b o=%h c=%b e=%b, required vld=1 o=%h c=%b e=0",
                         k, out_valid, o, cout, err, v[k].o, v[k].c);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask
`else
    task automatic test_mul_err();
        drive(3'd7, 16'h1234, 16'h5678);
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, o, cout, zero, err} !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL mul_err: vld=%b o=%h c=%b z=%b e=%b, required vld=1 o=0000 c=0 z=1 e=1",
                     out_valid, o, cout, zero, err);
        end
        out_ready = 1'b1;
        drive(3'd0, 16'h0001, 16'h0001);
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, o, err} !== {1'b1, 16'h0002, 1'b0}) begin
            bad++;
            $display("FAIL mul_err_clear: vld=%b o=%h e=%b, required vld=1 o=0002 e=0", out_valid, o, err);
        end
        step();
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0;
`ifdef ALU_MUL_EN
        drive(3'd7, 16'h00FF, 16'h0003);
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 8; c++) step();
`else
        drive(3'd0, 16'h0007, 16'h0009);
        step();
        in_valid = 1'b0;
        step();
`endif
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, o, cout, zero, err, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: vld=%b o=%h c=%b z=%b e=%b rdy=%b, required all 0",
                     out_valid, o, cout, zero, err, in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_no_output_%0d: out_valid=%b required 0", c, out_valid);
            end
        end
        drive(3'd0, 16'h0002, 16'h0003);
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, o, cout, zero} !== {1'b1, 16'h0005, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_add: vld=%b o=%h c=%b z=%b, required vld=1 o=0005 c=0 z=0",
                     out_valid, o, cout, zero);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_mul_err();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
